// File: rtl/scan_fsm_pkg.sv
// rtl/scan_fsm_pkg.sv - shared scan encodings, address-counter control words and ADC width
package scan_fsm_pkg;

    localparam int ADC_W  = 12;
    localparam int CTRL_W = 5;

    // Address-counter control: bit4 synchronous clear, bit0 increment
    localparam logic [CTRL_W-1:0] CTRL_CLR  = 5'b10000;
    localparam logic [CTRL_W-1:0] CTRL_INC  = 5'b00001;
    localparam logic [CTRL_W-1:0] CTRL_HOLD = 5'b00000;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ROW_SHIFT = 4'd1,
        S_ROW_RST   = 4'd2,
        S_COL_SHIFT = 4'd3,
        S_SETTLE    = 4'd4,
        S_CONVERT   = 4'd5,
        S_WRITE     = 4'd6,
        S_NEXT_ROW  = 4'd7,
        S_DONE      = 4'd8
    } scan_state_e;

endpackage

// File: rtl/scan_delay_cnt.sv
// rtl/scan_delay_cnt.sv - loadable down-counter with done flag for row-reset and settle waits
module scan_delay_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/scan_fsm.sv
// rtl/scan_fsm.sv - speckle pixel-matrix scan sequencer feeding the mode arbiter
// Optional column settling wait before each conversion: define SCAN_SETTLE_EN.
module scan_fsm #(
    parameter int ROWS          = 24,
    parameter int COLS          = 24,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_scan_go,
    output logic        o_adc_start,
    input  logic        i_adc_valid,
    input  logic [11:0] i_adc_data,
    output logic [4:0]  o_col_control,
    output logic [4:0]  o_row_control,
    output logic        o_ram_wren,
    output logic [11:0] o_ram_data,
    output logic        o_row_reg_data,
    output logic        o_row_reg_write,
    output logic        o_col_reg_data,
    output logic        o_col_reg_write,
    output logic        o_key_wren,
    output logic        o_row_rst,
    output logic        o_scan_end
);
    import scan_fsm_pkg::*;

    localparam int DLY_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam logic [DLY_W-1:0] RST_LOAD = DLY_W'(RST_CYCLES - 1);
`ifdef SCAN_SETTLE_EN
    localparam logic [DLY_W-1:0] SETTLE_LOAD = DLY_W'(SETTLE_CYCLES - 1);
`endif
    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [4:0] COL_LAST = 5'(COLS - 1);

    scan_state_e state_q, state_d;
    logic [4:0]  row_cnt_q, row_cnt_d;
    logic [4:0]  col_cnt_q, col_cnt_d;
    logic        dly_load, dly_done;
    logic [DLY_W-1:0] dly_val;

    logic             adc_start_q, adc_start_d;
    logic [CTRL_W-1:0] col_ctrl_q, col_ctrl_d;
    logic [CTRL_W-1:0] row_ctrl_q, row_ctrl_d;
    logic             ram_wren_q, ram_wren_d;
    logic [ADC_W-1:0] ram_data_q, ram_data_d;
    logic             row_reg_data_q, row_reg_data_d;
    logic             row_reg_write_q, row_reg_write_d;
    logic             col_reg_data_q, col_reg_data_d;
    logic             col_reg_write_q, col_reg_write_d;
    logic             row_rst_q, row_rst_d;
    logic             scan_end_q, scan_end_d;

    scan_delay_cnt #(.W(DLY_W)) u_dly (
        .clk        (clk),
        .rst        (rst),
        .i_load     (dly_load),
        .i_load_val (dly_val),
        .o_done     (dly_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            row_cnt_q       <= '0;
            col_cnt_q       <= '0;
            adc_start_q     <= 1'b0;
            col_ctrl_q      <= CTRL_CLR;
            row_ctrl_q      <= CTRL_CLR;
            ram_wren_q      <= 1'b0;
            ram_data_q      <= '0;
            row_reg_data_q  <= 1'b0;
            row_reg_write_q <= 1'b0;
            col_reg_data_q  <= 1'b0;
            col_reg_write_q <= 1'b0;
            row_rst_q       <= 1'b0;
            scan_end_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_cnt_q       <= row_cnt_d;
            col_cnt_q       <= col_cnt_d;
            adc_start_q     <= adc_start_d;
            col_ctrl_q      <= col_ctrl_d;
            row_ctrl_q      <= row_ctrl_d;
            ram_wren_q      <= ram_wren_d;
            ram_data_q      <= ram_data_d;
            row_reg_data_q  <= row_reg_data_d;
            row_reg_write_q <= row_reg_write_d;
            col_reg_data_q  <= col_reg_data_d;
            col_reg_write_q <= col_reg_write_d;
            row_rst_q       <= row_rst_d;
            scan_end_q      <= scan_end_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        dly_load  = 1'b0;
        dly_val   = RST_LOAD;
        case (state_q)
            S_IDLE:      if (i_scan_go) state_d = S_ROW_SHIFT;
            S_ROW_SHIFT: begin
                state_d  = S_ROW_RST;
                dly_load = 1'b1;
            end
            S_ROW_RST:   if (dly_done) state_d = S_COL_SHIFT;
`ifdef SCAN_SETTLE_EN
            S_COL_SHIFT: begin
                state_d  = S_SETTLE;
                dly_load = 1'b1;
                dly_val  = SETTLE_LOAD;
            end
            S_SETTLE:    if (dly_done) state_d = S_CONVERT;
`else
            S_COL_SHIFT: state_d = S_CONVERT;
`endif
            S_CONVERT:   if (i_adc_valid) state_d = S_WRITE;
            S_WRITE: begin
                if (col_cnt_q == COL_LAST) begin
                    col_cnt_d = '0;
                    state_d   = S_NEXT_ROW;
                end else begin
                    col_cnt_d = col_cnt_q + 5'd1;
                    state_d   = S_COL_SHIFT;
                end
            end
            S_NEXT_ROW: begin
                if (row_cnt_q == ROW_LAST) begin
                    state_d = S_DONE;
                end else begin
                    row_cnt_d = row_cnt_q + 5'd1;
                    state_d   = S_ROW_SHIFT;
                end
            end
            S_DONE:      if (!i_scan_go) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        // Losing go mid-scan abandons the scan, including any conversion in flight
        if (!i_scan_go && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_IDLE;
        end
        if (state_d == S_IDLE) begin
            row_cnt_d = '0;
            col_cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q
    always_comb begin
        adc_start_d     = 1'b0;
        col_ctrl_d      = CTRL_HOLD;
        row_ctrl_d      = CTRL_HOLD;
        ram_wren_d      = 1'b0;
        ram_data_d      = '0;
        row_reg_data_d  = 1'b0;
        row_reg_write_d = 1'b0;
        col_reg_data_d  = 1'b0;
        col_reg_write_d = 1'b0;
        row_rst_d       = 1'b0;
        scan_end_d      = 1'b0;
        case (state_d)
            S_IDLE: begin
                col_ctrl_d = CTRL_CLR;
                row_ctrl_d = CTRL_CLR;
            end
            S_ROW_SHIFT: begin
                row_reg_write_d = 1'b1;
                row_reg_data_d  = (row_cnt_d == '0);
            end
            S_ROW_RST:   row_rst_d = 1'b1;
            S_COL_SHIFT: begin
                col_reg_write_d = 1'b1;
                col_reg_data_d  = (col_cnt_d == '0);
            end
            S_CONVERT:   adc_start_d = (state_q != S_CONVERT);
            S_WRITE: begin
                ram_wren_d = 1'b1;
                ram_data_d = i_adc_data;
                col_ctrl_d = CTRL_INC;
            end
            S_NEXT_ROW: begin
                col_ctrl_d = CTRL_CLR;
                if (row_cnt_d != ROW_LAST) row_ctrl_d = CTRL_INC;
            end
            S_DONE:      scan_end_d = (state_q != S_DONE);
            default: ;
        endcase
    end

    assign o_adc_start     = adc_start_q;
    assign o_col_control   = col_ctrl_q;
    assign o_row_control   = row_ctrl_q;
    assign o_ram_wren      = ram_wren_q;
    assign o_ram_data      = ram_data_q;
    assign o_row_reg_data  = row_reg_data_q;
    assign o_row_reg_write = row_reg_write_q;
    assign o_col_reg_data  = col_reg_data_q;
    assign o_col_reg_write = col_reg_write_q;
    assign o_key_wren      = 1'b0;
    assign o_row_rst       = row_rst_q;
    assign o_scan_end      = scan_end_q;

endmodule

// File: tb/tb_scan_fsm.sv
// tb/tb_scan_fsm.sv - scoreboard bench for scan_fsm (2x2 matrix, 2-cycle row reset)
module tb_scan_fsm;

    localparam int SETTLE = 5;
`ifdef SCAN_SETTLE_EN
    localparam int GAP = SETTLE + 1;
`else
    localparam int GAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_scan_go;
    logic        i_adc_valid;
    logic [11:0] i_adc_data;
    logic        o_adc_start, o_ram_wren, o_row_reg_data, o_row_reg_write;
    logic        o_col_reg_data, o_col_reg_write, o_key_wren, o_row_rst, o_scan_end;
    logic [4:0]  o_col_control, o_row_control;
    logic [11:0] o_ram_data;

    int vectors = 0;
    int miscompares = 0;
    int wren_cnt = 0;
    int adc_idx = 0;
    logic [11:0] exp_q[$];
    logic [11:0] adc_tbl [8] = '{12'hA01, 12'hA02, 12'hA03, 12'hA04,
                                 12'h5A5, 12'h0FF, 12'h800, 12'hFFF};

    scan_fsm #(.ROWS(2), .COLS(2), .RST_CYCLES(2), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .i_scan_go(i_scan_go), .o_adc_start(o_adc_start),
        .i_adc_valid(i_adc_valid), .i_adc_data(i_adc_data),
        .o_col_control(o_col_control), .o_row_control(o_row_control),
        .o_ram_wren(o_ram_wren), .o_ram_data(o_ram_data),
        .o_row_reg_data(o_row_reg_data), .o_row_reg_write(o_row_reg_write),
        .o_col_reg_data(o_col_reg_data), .o_col_reg_write(o_col_reg_write),
        .o_key_wren(o_key_wren), .o_row_rst(o_row_rst), .o_scan_end(o_scan_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int others();
        return int'({o_adc_start, o_ram_wren, o_ram_data, o_row_reg_data, o_row_reg_write,
                     o_col_reg_data, o_col_reg_write, o_key_wren, o_row_rst, o_scan_end});
    endfunction

    // ADC model: answers each start 3 cycles later and records what a live scan must store
    initial begin
        i_adc_valid = 1'b0;
        i_adc_data  = '0;
        forever begin
            @(negedge clk);
            if (o_adc_start) begin
                repeat (3) @(posedge clk);
                #1;
                i_adc_data  = adc_tbl[adc_idx % 8];
                i_adc_valid = 1'b1;
                if (i_scan_go) begin
                    exp_q.push_back(i_adc_data);
                    adc_idx++;
                end
                @(posedge clk);
                #1;
                i_adc_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && o_ram_wren) begin
            wren_cnt++;
            if (exp_q.size() == 0) check("unexpected_wren", 1, 0);
            else check("ram_data", int'(o_ram_data), int'(exp_q.pop_front()));
        end
    end

    initial begin : main
        int rb[$], cb[$], rw[$];
        int exp_cb[4] = '{1, 0, 1, 0};
        int run, ends, cyc, last_col, starts, wr0;
        bit prev_rst, first_col;

        rst = 1'b1;
        i_scan_go = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_col_ctrl", o_col_control, 'h10);
        check("reset_row_ctrl", o_row_control, 'h10);
        check("reset_others", others(), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full scan with sequence capture
        i_scan_go = 1'b1;
        run = 0; ends = 0; cyc = 0; last_col = -100; prev_rst = 0; first_col = 0;
        while (ends == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (o_row_reg_write) begin rb.push_back(o_row_reg_data); first_col = 1; end
            if (o_row_rst) run++;
            else if (run != 0) begin rw.push_back(run); run = 0; end
            if (o_col_reg_write) begin
                cb.push_back(o_col_reg_data);
                if (first_col) begin check("rst_before_col", prev_rst, 1); first_col = 0; end
                last_col = cyc;
            end
            if (o_adc_start) check("col_to_adc_gap", cyc - last_col, GAP);
            if (o_scan_end) ends++;
            prev_rst = o_row_rst;
        end
        check("scan_end_seen", ends, 1);
        check("row_shift_count", rb.size(), 2);
        check("row_bit0", rb.size() > 0 ? rb[0] : -1, 1);
        check("row_bit1", rb.size() > 1 ? rb[1] : -1, 0);
        check("col_shift_count", cb.size(), 4);
        for (int i = 0; i < 4; i++) check("col_bit", cb.size() > i ? cb[i] : -1, exp_cb[i]);
        check("row_rst_pulses", rw.size(), 2);
        for (int i = 0; i < 2; i++) check("row_rst_width", rw.size() > i ? rw[i] : -1, 2);
        check("wren_count", wren_cnt, 4);
        check("scoreboard_drained", exp_q.size(), 0);

        // Go held high after completion: no restart
        starts = 0; ends = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_adc_start) starts++;
            if (o_scan_end) ends++;
        end
        check("done_no_adc_start", starts, 0);
        check("done_no_scan_end", ends, 0);
        check("done_col_ctrl", o_col_control, 0);
        i_scan_go = 1'b0;
        @(negedge clk);
        check("idle_after_drop_col", o_col_control, 'h10);
        check("idle_after_drop_row", o_row_control, 'h10);

        // Abort during the second conversion
        repeat (2) @(negedge clk);
        wr0 = wren_cnt;
        i_scan_go = 1'b1;
        starts = 0; cyc = 0;
        while (starts < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (o_adc_start) starts++;
        end
        check("abort_second_start", starts, 2);
        i_scan_go = 1'b0;
        @(negedge clk);
        check("abort_col_ctrl", o_col_control, 'h10);
        check("abort_row_ctrl", o_row_control, 'h10);
        check("abort_others", others(), 0);
        repeat (8) @(negedge clk);
        check("abort_wren_count", wren_cnt - wr0, 1);

        // Restart begins at row 0
        i_scan_go = 1'b1;
        cyc = 0;
        while (!o_row_reg_write && cyc < 50) begin @(negedge clk); cyc++; end
        check("restart_row_write", o_row_reg_write, 1);
        check("restart_row_bit", o_row_reg_data, 1);
        cyc = 0;
        while (!o_scan_end && cyc < 400) begin @(negedge clk); cyc++; end
        check("restart_scan_end", o_scan_end, 1);
        check("restart_drained", exp_q.size(), 0);
        i_scan_go = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a RAM write
        i_scan_go = 1'b1;
        cyc = 0;
        while (!o_ram_wren && cyc < 200) begin @(negedge clk); cyc++; end
        check("async_wren_before", o_ram_wren, 1);
        i_scan_go = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_wren_after", o_ram_wren, 0);
        check("async_col_ctrl", o_col_control, 'h10);
        check("async_row_ctrl", o_row_control, 'h10);
        check("async_others", others(), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
